// File: rtl/dino_motion_ctrl.sv
// dino_motion_ctrl
//   Per-frame game physics for the dino runner. On every frame_tick the block
//   advances the dino's vertical motion and pose, scrolls the obstacle, ramps
//   the scroll speed and counts the score. All outputs are registered and feed
//   the sprite renderer directly.
//
// Ports:
//   clk          in   system clock (VGA pixel/timing clock)
//   reset        in   synchronous, active-high
//   frame_tick   in   one-cycle pulse per frame; game state only moves on it
//   jump_btn     in   level, sampled on frame_tick
//   duck_btn     in   level, sampled on frame_tick
//   collision    in   level from renderer overlap detect, sampled on frame_tick
//   restart      in   one-cycle pulse, only acted on while dead
//   dino_y       out  [9:0]  dino sprite top y
//   obst_x       out  [10:0] obstacle sprite left x
//   sprite_sel   out  [1:0]  0=run 1=jump 2=duck 3=dead
//   anim_frame   out  run-leg animation phase
//   scroll_speed out  [3:0]  obstacle px/frame
//   score        out  [15:0] frames survived, saturating
//   game_over    out  high while dead
module dino_motion_ctrl #(
  parameter int GROUND_Y       = 400,
  parameter int JUMP_V0        = 12,
  parameter int GRAVITY        = 1,
  parameter int SCROLL_INIT    = 2,
  parameter int SCROLL_MAX     = 8,
  parameter int SPEEDUP_FRAMES = 600,
  parameter int OBST_RESPAWN_X = 1279,
  parameter int ANIM_FRAMES    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        jump_btn,
  input  logic        duck_btn,
  input  logic        collision,
  input  logic        restart,
  output logic [9:0]  dino_y,
  output logic [10:0] obst_x,
  output logic [1:0]  sprite_sel,
  output logic        anim_frame,
  output logic [3:0]  scroll_speed,
  output logic [15:0] score,
  output logic        game_over
);

  // State encoding doubles as the sprite select code.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_JUMP = 2'd1,
    ST_DUCK = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  localparam int PLAY_CNT_W = (SPEEDUP_FRAMES > 2) ? $clog2(SPEEDUP_FRAMES) : 1;
  localparam int ANIM_CNT_W = (ANIM_FRAMES > 2) ? $clog2(ANIM_FRAMES) : 1;

  localparam logic [PLAY_CNT_W-1:0] PLAY_LAST   = PLAY_CNT_W'(SPEEDUP_FRAMES - 1);
  localparam logic [ANIM_CNT_W-1:0] ANIM_LAST   = ANIM_CNT_W'(ANIM_FRAMES - 1);
  localparam logic [9:0]            GROUND_Y_U  = 10'(GROUND_Y);
  localparam logic signed [11:0]    GROUND_Y_S  = 12'(GROUND_Y);
  localparam logic signed [6:0]     JUMP_V0_S   = 7'(JUMP_V0);
  localparam logic signed [6:0]     GRAVITY_S   = 7'(GRAVITY);
  localparam logic [10:0]           RESPAWN_X   = 11'(OBST_RESPAWN_X);
  localparam logic [3:0]            SPEED_INIT  = 4'(SCROLL_INIT);
  localparam logic [3:0]            SPEED_MAX   = 4'(SCROLL_MAX);

  state_t                  state_reg, state_next;
  logic [9:0]              dino_y_reg, dino_y_next;
  logic signed [6:0]       vel_reg, vel_next;
  logic [10:0]             obst_x_reg, obst_x_next;
  logic [3:0]              speed_reg, speed_next;
  logic [15:0]             score_reg, score_next;
  logic                    anim_reg, anim_next;
  logic [ANIM_CNT_W-1:0]   anim_cnt_reg, anim_cnt_next;
  logic [PLAY_CNT_W-1:0]   play_cnt_reg, play_cnt_next;
  logic                    game_over_reg, game_over_next;

  logic signed [11:0]      next_y;
  logic                    advance;
  logic                    reinit;

  // Upward velocity is positive, so the next position is y minus velocity.
  assign next_y = $signed({2'b00, dino_y_reg}) - $signed({{5{vel_reg[6]}}, vel_reg});

  // World advances on live ticks only; the tick that registers a collision
  // is already treated as dead (no score, no scroll, no counters).
  assign advance = frame_tick && (state_reg != ST_DEAD) && !collision;

  // Restart is a plain pulse and needs no tick, but only counts while dead.
  assign reinit = reset || (restart && (state_reg == ST_DEAD));

  always_comb begin
    state_next     = state_reg;
    dino_y_next    = dino_y_reg;
    vel_next       = vel_reg;
    obst_x_next    = obst_x_reg;
    speed_next     = speed_reg;
    score_next     = score_reg;
    anim_next      = anim_reg;
    anim_cnt_next  = anim_cnt_reg;
    play_cnt_next  = play_cnt_reg;

    if (frame_tick) begin
      case (state_reg)
        ST_RUN: begin
          if (collision) begin
            state_next = ST_DEAD;
          end else if (jump_btn) begin
            state_next = ST_JUMP;
            vel_next   = JUMP_V0_S;
          end else if (duck_btn) begin
            state_next = ST_DUCK;
          end
        end
        ST_DUCK: begin
          if (collision) begin
            state_next = ST_DEAD;
          end else if (!duck_btn) begin
            state_next = ST_RUN;
          end
        end
        ST_JUMP: begin
          if (collision) begin
            state_next = ST_DEAD;
          end else if (vel_reg < 0 && next_y >= GROUND_Y_S) begin
            // Falling through the ground line: snap to ground and run.
            state_next  = ST_RUN;
            dino_y_next = GROUND_Y_U;
            vel_next    = '0;
          end else begin
            // Parameters keep the apex on screen, so the low bits are exact.
            dino_y_next = next_y[9:0];
            vel_next    = vel_reg - GRAVITY_S;
          end
        end
        default: begin
          state_next = ST_DEAD;
        end
      endcase
    end

    if (advance) begin
      // Wrap before the subtraction could underflow.
      if (obst_x_reg < 11'(speed_reg)) begin
        obst_x_next = RESPAWN_X;
      end else begin
        obst_x_next = obst_x_reg - 11'(speed_reg);
      end

      if (play_cnt_reg == PLAY_LAST) begin
        play_cnt_next = '0;
        if (speed_reg < SPEED_MAX) begin
          speed_next = speed_reg + 4'd1;
        end
      end else begin
        play_cnt_next = play_cnt_reg + 1'b1;
      end

      if (score_reg != 16'hFFFF) begin
        score_next = score_reg + 16'd1;
      end

      // Leg animation only runs (and only counts) while on the ground running.
      if (state_reg == ST_RUN) begin
        if (anim_cnt_reg == ANIM_LAST) begin
          anim_cnt_next = '0;
          anim_next     = ~anim_reg;
        end else begin
          anim_cnt_next = anim_cnt_reg + 1'b1;
        end
      end
    end

    game_over_next = (state_next == ST_DEAD);
  end

  always_ff @(posedge clk) begin
    if (reinit) begin
      state_reg     <= ST_RUN;
      dino_y_reg    <= GROUND_Y_U;
      vel_reg       <= '0;
      obst_x_reg    <= RESPAWN_X;
      speed_reg     <= SPEED_INIT;
      score_reg     <= '0;
      anim_reg      <= 1'b0;
      anim_cnt_reg  <= '0;
      play_cnt_reg  <= '0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dino_y_reg    <= dino_y_next;
      vel_reg       <= vel_next;
      obst_x_reg    <= obst_x_next;
      speed_reg     <= speed_next;
      score_reg     <= score_next;
      anim_reg      <= anim_next;
      anim_cnt_reg  <= anim_cnt_next;
      play_cnt_reg  <= play_cnt_next;
      game_over_reg <= game_over_next;
    end
  end

  assign dino_y       = dino_y_reg;
  assign obst_x       = obst_x_reg;
  assign sprite_sel   = state_reg;
  assign anim_frame   = anim_reg;
  assign scroll_speed = speed_reg;
  assign score        = score_reg;
  assign game_over    = game_over_reg;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed bench for dino_motion_ctrl: each tick is a one-cycle frame_tick
// followed by an idle cycle, outputs are sampled 1 time unit after the edge.
module tb_dino_motion_ctrl;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        jump_btn;
  logic        duck_btn;
  logic        collision;
  logic        restart;
  logic [9:0]  dino_y;
  logic [10:0] obst_x;
  logic [1:0]  sprite_sel;
  logic        anim_frame;
  logic [3:0]  scroll_speed;
  logic [15:0] score;
  logic        game_over;

  int n_checks = 0;
  int n_fail   = 0;

  dino_motion_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .jump_btn     (jump_btn),
    .duck_btn     (duck_btn),
    .collision    (collision),
    .restart      (restart),
    .dino_y       (dino_y),
    .obst_x       (obst_x),
    .sprite_sel   (sprite_sel),
    .anim_frame   (anim_frame),
    .scroll_speed (scroll_speed),
    .score        (score),
    .game_over    (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end else begin
      $display("ok   %s: %0d", tag, actual);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic tick(input logic j, input logic d, input logic c);
    frame_tick = 1'b1;
    jump_btn   = j;
    duck_btn   = d;
    collision  = c;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    jump_btn   = 1'b0;
    duck_btn   = 1'b0;
    collision  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; jump_btn = 1'b0; duck_btn = 1'b0;
    collision = 1'b0; restart = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check_val("rst dino_y", dino_y, 400);
    check_val("rst obst_x", obst_x, 1279);
    check_val("rst sprite", sprite_sel, 0);
    check_val("rst anim", anim_frame, 0);
    check_val("rst speed", scroll_speed, 2);
    check_val("rst score", score, 0);
    check_val("rst game_over", game_over, 0);

    // Plain running: anim toggles on the 6th tick
    run_ticks(5);
    check_val("run5 anim", anim_frame, 0);
    run_ticks(1);
    check_val("run6 anim", anim_frame, 1);
    run_ticks(4);
    check_val("run10 obst_x", obst_x, 1259);
    check_val("run10 score", score, 10);
    check_val("run10 anim", anim_frame, 1);
    check_val("run10 dino_y", dino_y, 400);
    check_val("run10 sprite", sprite_sel, 0);
    repeat (5) @(posedge clk);
    #1;
    check_val("no-tick hold score", score, 10);

    // Jump arc, jump_btn held in flight
    do_reset();
    tick(1'b1, 1'b0, 1'b0);
    check_val("jump start sprite", sprite_sel, 1);
    check_val("jump start dino_y", dino_y, 400);
    tick(1'b1, 1'b0, 1'b0);
    check_val("jump t1 dino_y", dino_y, 388);
    for (int i = 0; i < 11; i++) tick(1'b1, 1'b1, 1'b0);
    check_val("jump apex dino_y", dino_y, 322);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0);
    check_val("jump t24 dino_y", dino_y, 388);
    check_val("jump t24 sprite", sprite_sel, 1);
    tick(1'b0, 1'b0, 1'b0);
    check_val("land dino_y", dino_y, 400);
    check_val("land sprite", sprite_sel, 0);
    tick(1'b0, 1'b0, 1'b0);
    check_val("after land dino_y", dino_y, 400);
    check_val("after land score", score, 27);

    // Duck / jump priority
    do_reset();
    tick(1'b1, 1'b1, 1'b0);
    check_val("jump+duck sprite", sprite_sel, 1);
    do_reset();
    tick(1'b0, 1'b1, 1'b0);
    check_val("duck sprite", sprite_sel, 2);
    tick(1'b1, 1'b1, 1'b0);
    check_val("duck ignores jump sprite", sprite_sel, 2);
    check_val("duck ignores jump dino_y", dino_y, 400);
    tick(1'b0, 1'b0, 1'b0);
    check_val("duck release sprite", sprite_sel, 0);

    // Collision mid-jump at y=350
    do_reset();
    tick(1'b1, 1'b0, 1'b0);
    run_ticks(5);
    check_val("pre-hit dino_y", dino_y, 350);
    check_val("pre-hit score", score, 6);
    tick(1'b0, 1'b0, 1'b1);
    check_val("hit game_over", game_over, 1);
    check_val("hit sprite", sprite_sel, 3);
    check_val("hit dino_y", dino_y, 350);
    check_val("hit score", score, 6);
    check_val("hit obst_x", obst_x, 1267);
    tick(1'b1, 1'b0, 1'b0);
    run_ticks(2);
    check_val("dead score frozen", score, 6);
    check_val("dead dino_y frozen", dino_y, 350);
    check_val("dead obst_x frozen", obst_x, 1267);
    check_val("dead sprite", sprite_sel, 3);
    pulse_restart();
    check_val("restart dino_y", dino_y, 400);
    check_val("restart obst_x", obst_x, 1279);
    check_val("restart score", score, 0);
    check_val("restart game_over", game_over, 0);
    check_val("restart sprite", sprite_sel, 0);
    check_val("restart speed", scroll_speed, 2);
    run_ticks(2);
    pulse_restart();
    @(posedge clk); #1;
    check_val("restart in RUN score", score, 2);
    check_val("restart in RUN obst_x", obst_x, 1275);

    // Reset while dead
    tick(1'b0, 1'b0, 1'b1);
    check_val("hit2 game_over", game_over, 1);
    do_reset();
    check_val("reset from dead game_over", game_over, 0);
    check_val("reset from dead sprite", sprite_sel, 0);

    // Speed ramp and obstacle wrap
    run_ticks(599);
    check_val("t599 speed", scroll_speed, 2);
    check_val("t599 obst_x", obst_x, 81);
    run_ticks(1);
    check_val("t600 speed", scroll_speed, 3);
    check_val("t600 obst_x", obst_x, 79);
    run_ticks(25);
    check_val("t625 obst_x", obst_x, 4);
    run_ticks(1);
    check_val("t626 obst_x", obst_x, 1);
    run_ticks(1);
    check_val("t627 obst_x wrap", obst_x, 1279);
    run_ticks(3599 - 627);
    check_val("t3599 speed", scroll_speed, 7);
    run_ticks(1);
    check_val("t3600 speed", scroll_speed, 8);
    run_ticks(600);
    check_val("t4200 speed sat", scroll_speed, 8);
    check_val("t4200 score", score, 4200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
